// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scanner: active-low glyph codes {a..g}
// (a = MSB), the blank pattern and the nibble-to-glyph lookup.
package seven_seg_pkg;

  localparam int MAX_DIGITS = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_0   = 7'h01;
  localparam logic [6:0] GLYPH_1   = 7'h4F;
  localparam logic [6:0] GLYPH_2   = 7'h12;
  localparam logic [6:0] GLYPH_3   = 7'h06;
  localparam logic [6:0] GLYPH_4   = 7'h4C;
  localparam logic [6:0] GLYPH_5   = 7'h24;
  localparam logic [6:0] GLYPH_6   = 7'h20;
  localparam logic [6:0] GLYPH_7   = 7'h0F;
  localparam logic [6:0] GLYPH_8   = 7'h00;
  localparam logic [6:0] GLYPH_9   = 7'h04;
  localparam logic [6:0] GLYPH_A   = 7'h08;
  localparam logic [6:0] GLYPH_B   = 7'h60;
  localparam logic [6:0] GLYPH_C   = 7'h31;
  localparam logic [6:0] GLYPH_D   = 7'h42;
  localparam logic [6:0] GLYPH_E   = 7'h30;
  localparam logic [6:0] GLYPH_F   = 7'h38;

  typedef enum logic {
    PH_DEAD,
    PH_DRIVE
  } phase_e;

  function automatic logic [6:0] glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_glyph_rom.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_glyph_rom
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = glyph(nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode 7-segment driver: one digit per slot, a dead
// cycle at each slot start, per-digit enable and leading-zero blanking.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   hex_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      lz_blank,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg_n,
  output logic                      dp_n,
  output logic                      scan_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic                      slot_end;
  phase_e                    phase;
  logic [4*NUM_DIGITS-1:0]   hex_upper;
  logic [NUM_DIGITS-1:0]     sel_oh;
  logic                      dp_sel;
  logic                      en_sel;
  logic                      blank;
  logic [6:0]                glyph_seg;
  logic [NUM_DIGITS-1:0]     an_d;
  logic [6:0]                seg_d;
  logic                      dp_d;
  logic [NUM_DIGITS-1:0]     an_p1;
  logic [6:0]                seg_p1;
  logic                      dp_p1;
  logic                      tick_p1;

  assign slot_end = (cnt == CNT_LAST);
  assign phase    = (cnt == '0) ? PH_DEAD : PH_DRIVE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         cnt <= '0;
    else if (slot_end) cnt <= '0;
    else               cnt <= cnt + CNT_W'(1);
  end

  if (NUM_DIGITS > 1) begin : g_idx
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    always_ff @(posedge clk or posedge reset) begin
      if (reset)         idx <= '0;
      else if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end else begin : g_idx_fixed
    assign idx = '0;
  end

  // Nibbles at and above idx slide down to the bottom; all-zero means a leading zero.
  assign hex_upper = hex_in >> {idx, 2'b00};
  assign sel_oh    = NUM_DIGITS'(1) << idx;
  assign dp_sel    = |(dp_in & sel_oh);
  assign en_sel    = |(digit_en & sel_oh);
  assign blank     = !en_sel || (lz_blank && (idx != '0) && (hex_upper == '0));

  seg7_glyph_rom u_glyph_rom (
    .nibble (hex_upper[3:0]),
    .seg_n  (glyph_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (phase == PH_DRIVE && !blank) begin
      an_d  = ~sel_oh;
      seg_d = glyph_seg;
      dp_d  = ~dp_sel;
    end
  end

  // p1: registered pin drivers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_p1   <= '1;
      seg_p1  <= SEG_BLANK;
      dp_p1   <= 1'b1;
      tick_p1 <= 1'b0;
    end else begin
      an_p1   <= an_d;
      seg_p1  <= seg_d;
      dp_p1   <= dp_d;
      tick_p1 <= slot_end;
    end
  end

  assign an        = an_p1;
  assign seg_n     = seg_p1;
  assign dp_n      = dp_p1;
  assign scan_tick = tick_p1;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner: three configurations share clk/reset,
// an abstract per-edge reference model feeds queues, a monitor pops and compares.
module tb_seven_segment_scanner;

  typedef struct packed {
    logic [15:0] an;
    logic [6:0]  seg;
    logic        dp;
    logic        tick;
  } exp_t;

  localparam exp_t BLANK = '{an: 16'hFFFF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
  localparam logic [6:0] GLY [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Config A: 4 digits, 4-cycle slots
  logic [15:0] hex_a = 16'h0;
  logic [3:0]  dp_a = 4'h0, en_a = 4'hF;
  logic        lz_a = 1'b0;
  logic [3:0]  an_a;
  logic [6:0]  seg_a;
  logic        dpn_a, tick_a;
  // Config B: single digit, 2-cycle slots
  logic [3:0]  hex_b = 4'h0;
  logic [0:0]  dp_b = 1'b0, en_b = 1'b1;
  logic        lz_b = 1'b0;
  logic [0:0]  an_b;
  logic [6:0]  seg_b;
  logic        dpn_b, tick_b;
  // Config C: 8 digits, 5-cycle slots
  logic [31:0] hex_c = 32'h0;
  logic [7:0]  dp_c = 8'h0, en_c = 8'hFF;
  logic        lz_c = 1'b0;
  logic [7:0]  an_c;
  logic [6:0]  seg_c;
  logic        dpn_c, tick_c;

  seven_segment_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .hex_in(hex_a), .dp_in(dp_a), .digit_en(en_a),
    .lz_blank(lz_a), .an(an_a), .seg_n(seg_a), .dp_n(dpn_a), .scan_tick(tick_a));
  seven_segment_scanner #(.NUM_DIGITS(1), .REFRESH_DIV(2)) dut_b (
    .clk(clk), .reset(reset), .hex_in(hex_b), .dp_in(dp_b), .digit_en(en_b),
    .lz_blank(lz_b), .an(an_b), .seg_n(seg_b), .dp_n(dpn_b), .scan_tick(tick_b));
  seven_segment_scanner #(.NUM_DIGITS(8), .REFRESH_DIV(5)) dut_c (
    .clk(clk), .reset(reset), .hex_in(hex_c), .dp_in(dp_c), .digit_en(en_c),
    .lz_blank(lz_c), .an(an_c), .seg_n(seg_c), .dp_n(dpn_c), .scan_tick(tick_c));

  int checks = 0;
  int errors = 0;
  int n = 0;
  exp_t qa[$], qb[$], qc[$];

  // Output after edge n (n >= 1 since reset release): slot position and digit by plain arithmetic.
  function automatic exp_t model(int nd, int rd, int nn, logic [63:0] hex,
                                 logic [15:0] en, logic [15:0] dp, logic lz);
    exp_t e;
    int cnt, idx;
    logic [63:0] upper;
    bit blank;
    e = BLANK;
    cnt = (nn - 1) % rd;
    idx = ((nn - 1) / rd) % nd;
    e.tick = (cnt == rd - 1);
    upper = hex >> (4 * idx);
    blank = !en[idx] || (lz && idx > 0 && upper == 64'h0);
    if (cnt != 0 && !blank) begin
      e.an[idx] = 1'b0;
      e.seg = GLY[upper[3:0]];
      e.dp = ~dp[idx];
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      n = 0;
      qa.push_back(BLANK);
      qb.push_back(BLANK);
      qc.push_back(BLANK);
    end else begin
      n = n + 1;
      qa.push_back(model(4, 4, n, {48'h0, hex_a}, {12'h0, en_a}, {12'h0, dp_a}, lz_a));
      qb.push_back(model(1, 2, n, {60'h0, hex_b}, {15'h0, en_b}, {15'h0, dp_b}, lz_b));
      qc.push_back(model(8, 5, n, {32'h0, hex_c}, {8'h0, en_c}, {8'h0, dp_c}, lz_c));
    end
  end

  task automatic chk(input string nm, input exp_t e, input exp_t a);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t an=%h/%h seg=%h/%h dp=%b/%b tick=%b/%b (actual/required)",
               nm, $time, a.an, e.an, a.seg, e.seg, a.dp, e.dp, a.tick, e.tick);
    end
  endtask

  // Asynchronous reset forces the pins blank regardless of what the last edge produced.
  always @(negedge clk) begin
    exp_t e, a;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      if (reset) e = BLANK;
      a = '{an: {12'hFFF, an_a}, seg: seg_a, dp: dpn_a, tick: tick_a};
      chk("cfgA", e, a);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      if (reset) e = BLANK;
      a = '{an: {15'h7FFF, an_b}, seg: seg_b, dp: dpn_b, tick: tick_b};
      chk("cfgB", e, a);
    end
    if (qc.size() > 0) begin
      e = qc.pop_front();
      if (reset) e = BLANK;
      a = '{an: {8'hFF, an_c}, seg: seg_c, dp: dpn_c, tick: tick_c};
      chk("cfgC", e, a);
    end
  end

  function automatic logic [3:0] rnib();
    return ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
  endfunction

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  // Config B: glyph sweep, then random nibble/dp/enable changes
  initial begin
    wait (reset == 1'b0);
    @(posedge clk); #2;
    for (int v = 0; v < 16; v++) begin
      hex_b = 4'(v);
      cycles(4);
    end
    forever begin
      hex_b = 4'($urandom_range(0, 15));
      dp_b  = 1'($urandom_range(0, 1));
      en_b  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      lz_b  = 1'($urandom_range(0, 1));
      cycles(3);
    end
  end

  // Config C: sparse random changes over many frames
  initial begin
    forever begin
      @(posedge clk); #2;
      if ($urandom_range(0, 15) == 0) begin
        for (int i = 0; i < 8; i++) hex_c[4*i +: 4] = rnib();
        if ($urandom_range(0, 1) == 0) hex_c[31:16] = 16'h0;
        dp_c = 8'($urandom);
        en_c = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
        lz_c = 1'($urandom_range(0, 1));
      end
    end
  end

  // Config A: directed scenarios then random traffic; owns reset and the run length
  initial begin
    hex_a = 16'h12AF;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    cycles(40);
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    cycles(20);
    lz_a = 1'b1;
    hex_a = 16'h0050;
    cycles(32);
    hex_a = 16'h0000;
    cycles(32);
    lz_a = 1'b0;
    hex_a = 16'h8C3E;
    en_a = 4'b1010;
    dp_a = 4'b1111;
    cycles(32);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int j = 0; j < 4; j++) hex_a[4*j +: 4] = rnib();
        if ($urandom_range(0, 1) == 0) hex_a[15:8] = 8'h0;
        dp_a = 4'($urandom);
        en_a = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
        lz_a = 1'($urandom_range(0, 1));
      end
      cycles(1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
